// File: rtl/twos_comp_pkg.sv
// Shared constants and helpers for the two's-complement negator and its bench.
// MAX_WIDTH bounds the helper's return width; callers truncate to their own WIDTH.
package twos_comp_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 64;

  // 1 followed by (width-1) zeros: the most-negative two's-complement value.
  function automatic logic [MAX_WIDTH-1:0] most_neg(input int width);
    most_neg = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

endpackage

// File: rtl/twos_complementer_if.sv
// Operand/result bundle for twos_complementer; ovf exists only with TWOS_COMP_OVF_EN.
// master drives operands and observes results, slave is the negator.
interface twos_complementer_if
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             neg_en;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic [WIDTH-1:0] y;
`ifdef TWOS_COMP_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, neg_en, a,
`ifdef TWOS_COMP_OVF_EN
    input  ovf,
`endif
    input  out_valid, y
  );

  modport slave (
    input  in_valid, neg_en, a,
`ifdef TWOS_COMP_OVF_EN
    output ovf,
`endif
    output out_valid, y
  );

endinterface

// File: rtl/twos_complementer_neg_slice.sv
// One bit of the negation ripple chain; a is the operand bit already XORed with neg_en.
// Purely combinational, no handshake.
module neg_slice (
  input  logic a,
  input  logic cin,
  output logic cout,
  output logic y
);

  assign y    = a ^ cin;
  assign cout = a & cin;

endmodule

// File: rtl/twos_complementer.sv
// Registered two's-complement negator (y = neg_en ? -a : a); 1-cycle latency, no backpressure.
// Optional overflow flag for negating the most-negative value under TWOS_COMP_OVF_EN.
module twos_complementer
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  twos_complementer_if.slave   bus
);

  logic [WIDTH-1:0] carry;
  logic             msb_carry_unused;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             out_valid_q;

  assign carry[0] = bus.neg_en;

  // Invert-and-increment ripple: the MSB carry out wraps and is dropped.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    if (i < WIDTH - 1) begin : g_mid
      neg_slice u_slice (
        .a    (bus.a[i] ^ bus.neg_en),
        .cin  (carry[i]),
        .cout (carry[i+1]),
        .y    (y_d[i])
      );
    end else begin : g_msb
      neg_slice u_slice (
        .a    (bus.a[i] ^ bus.neg_en),
        .cin  (carry[i]),
        .cout (msb_carry_unused),
        .y    (y_d[i])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        y_q <= y_d;
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;

`ifdef TWOS_COMP_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

  logic ovf_d;
  logic ovf_q;

  assign ovf_d = bus.neg_en && (bus.a == MOST_NEG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_twos_complementer.sv
// Self-checking bench for twos_complementer (WIDTH=8): directed vectors with literal
// expectations plus a per-cycle comparison against an arithmetic reference model.
module tb_twos_complementer;
  import twos_comp_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   run_cmp  = 1'b0;

  logic [W-1:0] mdl_y;
  logic         mdl_vld;
  logic         mdl_ovf;

  twos_complementer_if #(.WIDTH(W)) bus ();

  twos_complementer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: plain arithmetic negation mod 2^W, registered one cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_y   <= '0;
      mdl_vld <= 1'b0;
      mdl_ovf <= 1'b0;
    end else begin
      mdl_vld <= bus.in_valid;
      if (bus.in_valid) begin
        mdl_y   <= bus.neg_en ? W'(0 - int'(bus.a)) : bus.a;
        mdl_ovf <= bus.neg_en && (int'(bus.a) == (1 << (W - 1)));
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      chk("cmp_out_valid", 32'(bus.out_valid), 32'(mdl_vld));
      chk("cmp_y", 32'(bus.y), 32'(mdl_y));
`ifdef TWOS_COMP_OVF_EN
      chk("cmp_ovf", 32'(bus.ovf), 32'(mdl_ovf));
`endif
    end
  end

  // Drive one operand, step one edge, check DUT and model against literals.
  task automatic apply(input string name, input logic vld, input logic neg,
                       input logic [W-1:0] a, input logic [W-1:0] exp_y,
                       input logic exp_ovf);
    bus.in_valid = vld;
    bus.neg_en   = neg;
    bus.a        = a;
    @(posedge clk);
    #1;
    chk({name, "_y"}, 32'(bus.y), 32'(exp_y));
    chk({name, "_vld"}, 32'(bus.out_valid), 32'(vld));
    chk({name, "_model"}, 32'(mdl_y), 32'(exp_y));
`ifdef TWOS_COMP_OVF_EN
    chk({name, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
    if (exp_ovf) chk({name, "_model_ovf"}, 32'(mdl_ovf), 32'(exp_ovf));
`endif
  endtask

  initial begin
    logic [W-1:0] mn;
    mn = W'(most_neg(W));
    bus.in_valid = 1'b0;
    bus.neg_en   = 1'b0;
    bus.a        = '0;

    #12;
    chk("reset_y", 32'(bus.y), 32'h0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
`ifdef TWOS_COMP_OVF_EN
    chk("reset_ovf", 32'(bus.ovf), 32'h0);
`endif
    chk("most_neg_fn", 32'(mn), 32'h80);

    @(negedge clk);
    rst = 1'b0;
    run_cmp = 1'b1;

    apply("neg_82", 1'b1, 1'b1, 8'h82, 8'h7E, 1'b0);
    apply("neg_01", 1'b1, 1'b1, 8'h01, 8'hFF, 1'b0);
    apply("neg_7f", 1'b1, 1'b1, 8'h7F, 8'h81, 1'b0);
    apply("neg_00", 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    apply("neg_80", 1'b1, 1'b1, mn,    8'h80, 1'b1);
    apply("pass_80", 1'b1, 1'b0, 8'h80, 8'h80, 1'b0);
    apply("pass_5a", 1'b1, 1'b0, 8'h5A, 8'h5A, 1'b0);
    apply("neg_5a", 1'b1, 1'b1, 8'h5A, 8'hA6, 1'b0);
    apply("hold", 1'b0, 1'b1, 8'h33, 8'hA6, 1'b0);
    apply("neg_ff", 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);

    // Asynchronous reset between edges while a result is valid.
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_y", 32'(bus.y), 32'h0);
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("post_rst_y", 32'(bus.y), 32'h0);

    for (int i = 0; i < 1000; i++) begin
      bus.a        = W'($urandom_range(0, (1 << W) - 1));
      bus.neg_en   = 1'($urandom_range(0, 1));
      bus.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end

    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    run_cmp = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
